lcd_hd44780_if: RTL and testbench

//  Responder side of the lcd_row/lcd_col/lcd_char/lcd_we/lcd_busy character-write interface.

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_nibble_tx.sv | 89 ++++++++
 rtl/lcd_hd44780_if.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_hd44780_if.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and byte-building helpers for the HD44780
// character-write interface.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_4B = 8'h28;
  localparam logic [7:0] ENTRY_INC   = 8'h06;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] SET_DDRAM   = 8'h80;
  localparam logic [6:0] ROW1_OFS    = 7'h40;

  typedef enum logic [2:0] {
    StPwrWait,
    StInitN,
    StCfg,
    StIdle,
    StAddr,
    StData
  } lcd_state_e;

  // Sub-steps of sending one byte (init nibbles use only PhLo/PhSettle).
  typedef enum logic [2:0] {
    PhStart,
    PhHi,
    PhGap,
    PhLo,
    PhSettle
  } lcd_phase_e;

  typedef enum logic [1:0] {
    NtIdle,
    NtSetup,
    NtPulse,
    NtHold
  } nib_state_e;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = FUNC_SET_4B;
      2'd1: b = ENTRY_INC;
      2'd2: b = DISP_ON;
      2'd3: b = CLEAR;
      default: b = CLEAR;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    logic [6:0] a;
    a = (row ? ROW1_OFS : 7'h00) | {3'b000, col};
    return SET_DDRAM | {1'b0, a};
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one 4-bit transfer onto the LCD pins: setup, E pulse, one hold cycle,
// then a single-cycle done.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned TSetup  = 2,
  parameter int unsigned TEPulse = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] nibble_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] d_o,
  output logic       done_o
);

  localparam int unsigned CntMax = (TSetup > TEPulse) ? TSetup : TEPulse;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  nib_state_e      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [3:0]      d_q, d_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q  <= NtIdle;
      cnt_q <= '0;
      e_q   <= 1'b0;
      rs_q  <= 1'b0;
      d_q   <= 4'h0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      e_q   <= e_d;
      rs_q  <= rs_d;
      d_q   <= d_d;
    end
  end

  // RS/D keep their value after the hold cycle until the next nibble starts.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    e_d   = e_q;
    rs_d  = rs_q;
    d_d   = d_q;
    unique case (st_q)
      NtIdle: begin
        if (start_i) begin
          rs_d  = rs_i;
          d_d   = nibble_i;
          cnt_d = '0;
          st_d  = NtSetup;
        end
      end
      NtSetup: begin
        if (cnt_q == CntW'(TSetup - 1)) begin
          e_d   = 1'b1;
          cnt_d = '0;
          st_d  = NtPulse;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NtPulse: begin
        if (cnt_q == CntW'(TEPulse - 1)) begin
          e_d   = 1'b0;
          cnt_d = '0;
          st_d  = NtHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NtHold: st_d = NtIdle;
      default: st_d = NtIdle;
    endcase
  end

  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign d_o    = d_q;
  assign done_o = (st_q == NtHold);

endmodule

// File: rtl/lcd_hd44780_if.sv
// HD44780 4-bit responder: power-on init, then one DDRAM-address command plus
// one data byte per accepted character write.
module lcd_hd44780_if
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 12,
  parameter int unsigned T_NIBGAP  = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       lcd_row,
  input  logic [3:0] lcd_col,
  input  logic [7:0] lcd_char,
  input  logic       lcd_we,
  output logic       lcd_busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam int unsigned CntW = $clog2(T_POWERON + 1);

  lcd_state_e      state_q, state_d;
  lcd_phase_e      phase_q, phase_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            init_done_q, init_done_d;
  logic            row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [7:0]      char_q, char_d;

  logic            tx_start, tx_rs, tx_done;
  logic [3:0]      tx_nib;
  logic [7:0]      cur_byte;
  int unsigned     wait_len;
  logic            cnt_end;

  lcd_nibble_tx #(
    .TSetup  (T_SETUP),
    .TEPulse (T_EPULSE)
  ) u_nibble_tx (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .start_i  (tx_start),
    .rs_i     (tx_rs),
    .nibble_i (tx_nib),
    .e_o      (lcd_e),
    .rs_o     (lcd_rs),
    .d_o      (lcd_d),
    .done_o   (tx_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StPwrWait;
      phase_q     <= PhStart;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= 4'h0;
      char_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      char_q      <= char_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StCfg:   cur_byte = cfg_byte(idx_q);
      StAddr:  cur_byte = ddram_addr(row_q, col_q);
      StData:  cur_byte = char_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Length of whatever the shared counter is currently timing.
  always_comb begin
    wait_len = T_CMD;
    if (state_q == StPwrWait) begin
      wait_len = T_POWERON;
    end else if (phase_q == PhGap) begin
      wait_len = T_NIBGAP;
    end else if (state_q == StInitN) begin
      if (idx_q == 2'd0) begin
        wait_len = T_INIT1;
      end else if (idx_q == 2'd1) begin
        wait_len = T_INIT2;
      end
    end else if (state_q == StCfg && idx_q == 2'd3) begin
      wait_len = T_CLEAR;
    end
  end

  assign cnt_end = (cnt_q == CntW'(wait_len - 1));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    row_d       = row_q;
    col_d       = col_q;
    char_d      = char_q;
    tx_start    = 1'b0;
    tx_rs       = (state_q == StData);
    tx_nib      = cur_byte[7:4];

    unique case (state_q)
      StPwrWait: begin
        if (cnt_end) begin
          tx_start = 1'b1;
          tx_nib   = 4'h3;
          state_d  = StInitN;
          phase_d  = PhLo;
          idx_d    = 2'd0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (lcd_we) begin
          row_d   = lcd_row;
          col_d   = lcd_col;
          char_d  = lcd_char;
          busy_d  = 1'b1;
          state_d = StAddr;
          phase_d = PhStart;
        end
      end
      default: begin
        unique case (phase_q)
          PhStart: begin
            tx_start = 1'b1;
            phase_d  = PhHi;
          end
          PhHi: begin
            if (tx_done) begin
              phase_d = PhGap;
              cnt_d   = '0;
            end
          end
          PhGap: begin
            if (cnt_end) begin
              tx_start = 1'b1;
              tx_nib   = cur_byte[3:0];
              phase_d  = PhLo;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PhLo: begin
            if (tx_done) begin
              phase_d = PhSettle;
              cnt_d   = '0;
            end
          end
          PhSettle: begin
            if (cnt_end) begin
              cnt_d = '0;
              // Next transfer launches on the same edge the settle ends.
              unique case (state_q)
                StInitN: begin
                  tx_start = 1'b1;
                  if (idx_q == 2'd3) begin
                    tx_nib  = FUNC_SET_4B[7:4];
                    state_d = StCfg;
                    idx_d   = 2'd0;
                    phase_d = PhHi;
                  end else begin
                    tx_nib  = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                    idx_d   = 2'(idx_q + 2'd1);
                    phase_d = PhLo;
                  end
                end
                StCfg: begin
                  if (idx_q == 2'd3) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    init_done_d = 1'b1;
                  end else begin
                    tx_start = 1'b1;
                    tx_nib   = cfg_byte(2'(idx_q + 2'd1)) >> 4;
                    idx_d    = 2'(idx_q + 2'd1);
                    phase_d  = PhHi;
                  end
                end
                StAddr: begin
                  tx_start = 1'b1;
                  tx_rs    = 1'b1;
                  tx_nib   = char_q[7:4];
                  state_d  = StData;
                  phase_d  = PhHi;
                end
                default: begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: phase_d = PhStart;
        endcase
      end
    endcase
  end

  assign lcd_busy  = busy_q;
  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_if.sv
// Bench for lcd_hd44780_if: pin-level nibble monitor compared against a byte-level
// model of the expected HD44780 transfer stream, plus timing and handshake checks.
module tb_lcd_hd44780_if;

  localparam int unsigned T_POWERON = 20;
  localparam int unsigned T_INIT1   = 10;
  localparam int unsigned T_INIT2   = 5;
  localparam int unsigned T_CMD     = 4;
  localparam int unsigned T_CLEAR   = 8;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_EPULSE  = 12;
  localparam int unsigned T_NIBGAP  = 3;
  localparam int unsigned BYTE_T    = 2 * (T_SETUP + T_EPULSE + 1) + T_NIBGAP + T_CMD;
  localparam int unsigned WR_LAT    = 2 * BYTE_T + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       lcd_row = 1'b0;
  logic [3:0] lcd_col = 4'h0;
  logic [7:0] lcd_char = 8'h00;
  logic       lcd_we = 1'b0;
  logic       lcd_busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  always #5 CLK = ~CLK;

  lcd_hd44780_if #(
    .T_POWERON (T_POWERON),
    .T_INIT1   (T_INIT1),
    .T_INIT2   (T_INIT2),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR),
    .T_SETUP   (T_SETUP),
    .T_EPULSE  (T_EPULSE),
    .T_NIBGAP  (T_NIBGAP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .lcd_row   (lcd_row),
    .lcd_col   (lcd_col),
    .lcd_char  (lcd_char),
    .lcd_we    (lcd_we),
    .lcd_busy  (lcd_busy),
    .init_done (init_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d)
  );

  int checks = 0;
  int failures = 0;

  // Monitor-owned records (written only by the monitor).
  logic [4:0] obs_nib [0:511];
  int         obs_wr = 0;
  int         w_arr [0:511];
  int         w_wr = 0;
  int         s_arr [0:511];
  int         s_wr = 0;
  int         hold_bad = 0;
  logic       prev_e = 1'b0;
  logic [4:0] prev_rsd = 5'h0;
  int         hi_cnt = 0;
  int         stable_cnt = 0;

  // Model / reader state (written only by the main sequence).
  logic [4:0] exp_nib [0:511];
  int         exp_wr = 0;
  int         exp_rd = 0;
  int         obs_rd = 0;
  int         w_rd = 0;
  int         s_rd = 0;
  int         hold_base = 0;

  always @(negedge CLK) begin
    prev_e   <= lcd_e;
    prev_rsd <= {lcd_rs, lcd_d};
    if (lcd_e && !prev_e) begin
      obs_nib[obs_wr] <= {lcd_rs, lcd_d};
      obs_wr          <= obs_wr + 1;
      s_arr[s_wr]     <= ({lcd_rs, lcd_d} == prev_rsd) ? stable_cnt : 0;
      s_wr            <= s_wr + 1;
    end
    if (lcd_e) hi_cnt <= prev_e ? hi_cnt + 1 : 1;
    else stable_cnt <= ({lcd_rs, lcd_d} == prev_rsd) ? stable_cnt + 1 : 1;
    if (!lcd_e && prev_e) begin
      w_arr[w_wr] <= hi_cnt;
      w_wr        <= w_wr + 1;
    end
    if (prev_e && ({lcd_rs, lcd_d} != prev_rsd)) hold_bad <= hold_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] n);
    exp_nib[exp_wr] = {rs, n};
    exp_wr++;
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
  endtask

  task automatic exp_init();
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h2);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic exp_write(input logic r, input logic [3:0] c, input logic [7:0] ch);
    push_byte(1'b0, 8'h80 + (r ? 8'h40 : 8'h00) + {4'h0, c});
    push_byte(1'b1, ch);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, obs_wr - obs_rd, exp_wr - exp_rd);
    while (exp_rd < exp_wr && obs_rd < obs_wr) begin
      chk(tag, {27'd0, obs_nib[obs_rd]}, {27'd0, exp_nib[exp_rd]});
      obs_rd++;
      exp_rd++;
    end
    obs_rd = obs_wr;
    exp_rd = exp_wr;
  endtask

  task automatic check_timing();
    while (w_rd < w_wr) begin
      chk("e_width", w_arr[w_rd], T_EPULSE);
      w_rd++;
    end
    while (s_rd < s_wr) begin
      chk("setup_ok", {31'd0, s_arr[s_rd] >= int'(T_SETUP)}, 1);
      s_rd++;
    end
    chk("hold_stable", hold_bad - hold_base, 0);
  endtask

  task automatic reset_and_init(input string tag);
    int base;
    int cnt;
    int tog_bad;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_rst_pins"}, {lcd_e, lcd_rs, lcd_rw, lcd_d, lcd_busy, init_done}, 9'b0_0000_0010);
    exp_init();
    base = obs_wr;
    @(negedge CLK);
    RST = 1'b1;
    repeat (T_POWERON) @(posedge CLK);
    #1;
    chk({tag, "_pwr_quiet"}, obs_wr - base, 0);
    chk({tag, "_pwr_e_low"}, lcd_e, 0);
    cnt = 0;
    tog_bad = 0;
    while (lcd_busy && cnt < 3000) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (lcd_busy == init_done) tog_bad++;
    end
    chk({tag, "_init_busy_low"}, lcd_busy, 0);
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_busy_done_together"}, tog_bad, 0);
    @(negedge CLK);
    check_stream({tag, "_init_stream"});
    check_timing();
  endtask

  task automatic start_write(input logic r, input logic [3:0] c, input logic [7:0] ch);
    @(negedge CLK);
    chk("ready_before_write", lcd_busy, 0);
    lcd_row  = r;
    lcd_col  = c;
    lcd_char = ch;
    lcd_we   = 1'b1;
    @(posedge CLK);
    #1;
    lcd_we = 1'b0;
    chk("busy_after_accept", lcd_busy, 1);
    exp_write(r, c, ch);
  endtask

  // Waits for busy to fall; optionally pulses a stray write or raises lcd_we early.
  task automatic wait_idle(output int lat, input int inj_at, input int hold_at,
                           input logic hr, input logic [3:0] hc, input logic [7:0] hch);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat == inj_at) begin
        lcd_we   = 1'b1;
        lcd_char = 8'h5A;
        lcd_row  = ~lcd_row;
        lcd_col  = lcd_col + 4'd1;
      end else if (lat == inj_at + 1) begin
        lcd_we = 1'b0;
      end
      if (lat == hold_at) begin
        lcd_we   = 1'b1;
        lcd_row  = hr;
        lcd_col  = hc;
        lcd_char = hch;
      end
    end while (lcd_busy && lat < 4000);
  endtask

  initial begin
    int lat;
    int base;
    int cnt;
    logic r;
    logic [3:0] c;
    logic [7:0] ch;

    // 1: power-on init
    reset_and_init("t1");

    // 2: row0 col5 'H'
    start_write(1'b0, 4'd5, 8'h48);
    wait_idle(lat, -1, -1, 1'b0, 4'h0, 8'h00);
    chk("t2_latency", lat, WR_LAT);
    @(negedge CLK);
    check_stream("t2_stream");
    check_timing();

    // 3: row1 col15 '!'
    start_write(1'b1, 4'd15, 8'h21);
    wait_idle(lat, -1, -1, 1'b0, 4'h0, 8'h00);
    chk("t3_latency", lat, WR_LAT);
    @(negedge CLK);
    check_stream("t3_stream");

    // 4: stray write while busy is ignored
    start_write(1'b0, 4'd3, 8'h33);
    wait_idle(lat, 30, -1, 1'b0, 4'h0, 8'h00);
    chk("t4_latency", lat, WR_LAT);
    @(negedge CLK);
    chk("t4_still_idle", lcd_busy, 0);
    check_stream("t4_stream");

    // randomized writes
    for (int i = 0; i < 5; i++) begin
      r  = 1'($urandom_range(0, 1));
      c  = 4'($urandom_range(0, 15));
      ch = 8'($urandom_range(0, 255));
      start_write(r, c, ch);
      wait_idle(lat, -1, -1, 1'b0, 4'h0, 8'h00);
      chk("rnd_latency", lat, WR_LAT);
      @(negedge CLK);
      check_stream("rnd_stream");
    end
    check_timing();

    // 6: lcd_we held across busy falling edge
    start_write(1'b0, 4'd9, 8'h7E);
    wait_idle(lat, -1, 40, 1'b1, 4'd0, 8'h41);
    chk("t6_latency_first", lat, WR_LAT);
    @(posedge CLK);
    #1;
    lcd_we = 1'b0;
    chk("t6_accept_on_fall", lcd_busy, 1);
    exp_write(1'b1, 4'd0, 8'h41);
    wait_idle(lat, -1, -1, 1'b0, 4'h0, 8'h00);
    chk("t6_latency_second", lat, WR_LAT);
    @(negedge CLK);
    check_stream("t6_stream");
    check_timing();

    // 5: reset during the data lower-nibble E pulse
    start_write(1'b0, 4'd7, 8'h55);
    base = obs_wr - 0;
    cnt = 0;
    while ((obs_wr - base) < 3 && cnt < 2000) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    // obs_wr already counted the accept-time state; wait for the 4th rise of this write
    cnt = 0;
    while ((obs_wr - obs_rd) < 4 && cnt < 2000) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_e_high_before_rst", lcd_e, 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("t5_e_dropped", lcd_e, 0);
    chk("t5_busy", lcd_busy, 1);
    chk("t5_init_done_clr", init_done, 0);
    @(negedge CLK);
    @(negedge CLK);
    check_stream("t5_abort_stream");
    w_rd      = w_wr;
    hold_base = hold_bad;
    reset_and_init("t5");

    r  = 1'($urandom_range(0, 1));
    c  = 4'($urandom_range(0, 15));
    ch = 8'($urandom_range(0, 255));
    start_write(r, c, ch);
    wait_idle(lat, -1, -1, 1'b0, 4'h0, 8'h00);
    chk("t5_post_latency", lat, WR_LAT);
    @(negedge CLK);
    check_stream("t5_post_stream");
    check_timing();
    chk("rw_low", lcd_rw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
